// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one data bus between fetch and the memory stage.
// Round-robin grant in IDLE, registered bus request, response routed back.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   ireq / iresp      fetch request / response (ibus style)
//   dreq_in/dresp_out memory-stage request / response (dbus style)
//   bus_req/bus_resp  shared bus request (registered) / response
//   busy              high whenever a grant is outstanding

package mem_bus_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter msize_t  FETCH_SIZE   = MSIZE4,
    parameter strobe_t FETCH_STROBE = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq_in,
    output dbus_resp_t dresp_out,
    output dbus_req_t  bus_req,
    input  dbus_resp_t bus_resp,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   last_d;
    logic   done;

    // addr_ok alone does not finish a transaction
    assign done = bus_resp.addr_ok & bus_resp.data_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Ties go to whichever side was not served last
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (dreq_in.valid && (!ireq.valid || !last_d)) begin
                    state_nx = GRANT_D;
                end else if (ireq.valid) begin
                    state_nx = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request is latched at the grant edge and frozen until completion,
    // so requester-side changes mid-grant never reach the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req <= '0;
            last_d  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (state_nx == GRANT_D) begin
                        bus_req.valid  <= 1'b1;
                        bus_req.addr   <= dreq_in.addr;
                        bus_req.size   <= dreq_in.size;
                        bus_req.strobe <= dreq_in.strobe;
                        bus_req.data   <= dreq_in.data;
                    end else if (state_nx == GRANT_I) begin
                        bus_req.valid  <= 1'b1;
                        bus_req.addr   <= ireq.addr;
                        bus_req.size   <= FETCH_SIZE;
                        bus_req.strobe <= FETCH_STROBE;
                        bus_req.data   <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (done) begin
                        bus_req.valid <= 1'b0;
                        last_d        <= (state == GRANT_D);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy              = (state != IDLE);
        iresp.data        = bus_resp.data;
        iresp.addr_ok     = (state == GRANT_I) & done;
        iresp.data_ok     = (state == GRANT_I) & done;
        dresp_out.data    = bus_resp.data;
        dresp_out.addr_ok = (state == GRANT_D) & done;
        dresp_out.data_ok = (state == GRANT_D) & done;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic for
// mem_bus_arbiter, checked against a transaction-level owner model.

module tb_mem_bus_arbiter;

    import mem_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    ibus_req_t  ireq = '0;
    ibus_resp_t iresp;
    dbus_req_t  dreq_in = '0;
    dbus_resp_t dresp_out;
    dbus_req_t  bus_req;
    dbus_resp_t bus_resp = '0;
    logic       busy;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .ireq     (ireq),
        .iresp    (iresp),
        .dreq_in  (dreq_in),
        .dresp_out(dresp_out),
        .bus_req  (bus_req),
        .bus_resp (bus_resp),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: who owns the bus (0 none, 1 fetch, 2 data), who was
    // served last, and the request that should sit on the bus.
    int        m_owner  = 0;
    bit        m_last_d = 1'b0;
    dbus_req_t m_req    = '0;
    bit        i_done   = 1'b0;
    bit        d_done   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_last_d = 1'b0;
        m_req    = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;
    endtask

    task automatic model_edge();
        int pick;
        i_done = 1'b0;
        d_done = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner == 0) begin
            pick = 0;
            if (dreq_in.valid && ireq.valid) pick = m_last_d ? 1 : 2;
            else if (dreq_in.valid)          pick = 2;
            else if (ireq.valid)             pick = 1;
            if (pick == 2) begin
                m_req       = dreq_in;
                m_req.valid = 1'b1;
            end else if (pick == 1) begin
                m_req.valid  = 1'b1;
                m_req.addr   = ireq.addr;
                m_req.size   = MSIZE4;
                m_req.strobe = '0;
                m_req.data   = '0;
            end
            m_owner = pick;
        end else if (bus_resp.addr_ok && bus_resp.data_ok) begin
            m_last_d    = (m_owner == 2);
            i_done      = (m_owner == 1);
            d_done      = (m_owner == 2);
            m_req.valid = 1'b0;
            m_owner     = 0;
        end
    endtask

    task automatic check_outputs();
        logic ok;
        logic [1:0] exp_i;
        logic [1:0] exp_d;
        ok    = bus_resp.addr_ok & bus_resp.data_ok;
        exp_i = (m_owner == 1 && ok) ? 2'b11 : 2'b00;
        exp_d = (m_owner == 2 && ok) ? 2'b11 : 2'b00;
        chk("bus_valid", 64'(bus_req.valid), 64'(m_req.valid));
        if (m_req.valid) begin
            chk("bus_addr", 64'(bus_req.addr), 64'(m_req.addr));
            chk("bus_size", 64'(bus_req.size), 64'(m_req.size));
            chk("bus_strobe", 64'(bus_req.strobe), 64'(m_req.strobe));
            chk("bus_data", 64'(bus_req.data), 64'(m_req.data));
        end
        chk("busy", 64'(busy), 64'(m_owner != 0));
        chk("iresp_ok", 64'({iresp.addr_ok, iresp.data_ok}), 64'(exp_i));
        chk("dresp_ok", 64'({dresp_out.addr_ok, dresp_out.data_ok}),
            64'(exp_d));
        chk("iresp_data", 64'(iresp.data), 64'(bus_resp.data));
        chk("dresp_data", 64'(dresp_out.data), 64'(bus_resp.data));
    endtask

    // Inputs are set just after a rising edge; outputs checked at the
    // falling edge; model advanced at the next rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        bus_resp.data = $urandom;
    endtask

    task automatic set_ok(input logic a, input logic d);
        bus_resp.addr_ok = a;
        bus_resp.data_ok = d;
    endtask

    task automatic complete_after(input int n);
        set_ok(1'b0, 1'b0);
        repeat (n) cycle();
        set_ok(1'b1, 1'b1);
        cycle();
        set_ok(1'b0, 1'b0);
    endtask

    task automatic dset(input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
        dreq_in.valid  = 1'b1;
        dreq_in.addr   = a;
        dreq_in.size   = MSIZE4;
        dreq_in.strobe = s;
        dreq_in.data   = d;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] tie_addr [3];
        tie_addr[0] = 32'h0000_3000;
        tie_addr[1] = 32'h8000_0100;
        tie_addr[2] = 32'h0000_3004;

        // Reset state
        cycle();
        chk("rst_valid", 64'(bus_req.valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        cycle();

        // Fetch only
        ireq = '{valid: 1'b1, addr: 32'h8000_0000};
        cycle();
        chk("fetch_size", 64'(bus_req.size), 64'(MSIZE4));
        chk("fetch_strobe", 64'(bus_req.strobe), 64'd0);
        complete_after(2);
        ireq = '0;
        cycle();

        // Data store only
        dset(32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
        cycle();
        chk("store_addr", 64'(bus_req.addr), 64'h1000);
        chk("store_data", 64'(bus_req.data), 64'hDEAD_BEEF);
        complete_after(1);
        dreq_in = '0;
        cycle();

        // Round-robin ties from reset: D, I, D
        pulse_reset();
        ireq = '{valid: 1'b1, addr: 32'h8000_0100};
        dset(32'h0000_3000, 4'h3, 32'h1111_2222);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("tie_%0d", k), 64'(bus_req.addr),
                64'(tie_addr[k]));
            complete_after(1);
            if (k == 0) dreq_in.addr = 32'h0000_3004;
        end
        ireq    = '0;
        dreq_in = '0;
        cycle();

        // Requester fields change mid-grant
        dset(32'h0000_1000, 4'hF, 32'h0BAD_F00D);
        cycle();
        dreq_in.addr = 32'h0000_2000;
        cycle();
        chk("hold_addr", 64'(bus_req.addr), 64'h1000);
        complete_after(1);
        dreq_in = '0;
        cycle();

        // addr_ok alone is ignored
        ireq = '{valid: 1'b1, addr: 32'h8000_0200};
        cycle();
        set_ok(1'b1, 1'b0);
        cycle();
        cycle();
        chk("aok_busy", 64'(busy), 64'd1);
        chk("aok_no_resp", 64'(iresp.data_ok), 64'd0);
        complete_after(0);
        ireq = '0;
        cycle();
        chk("aok_idle", 64'(busy), 64'd0);

        // Reset while data grant pending, then a tie goes to D
        dset(32'h0000_4000, 4'h1, 32'h5555_AAAA);
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(bus_req.valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        model_reset();
        cycle();
        rst  = 1'b0;
        ireq = '{valid: 1'b1, addr: 32'h8000_0300};
        dset(32'h0000_4400, 4'h2, 32'h0);
        cycle();
        chk("rst_tie_d", 64'(bus_req.addr), 64'h4400);
        complete_after(1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!ireq.valid || i_done) begin
                if ($urandom_range(0, 1) == 1)
                    ireq = '{valid: 1'b1, addr: $urandom};
                else
                    ireq = '0;
            end
            if (!dreq_in.valid || d_done) begin
                if ($urandom_range(0, 1) == 1) begin
                    dreq_in.valid  = 1'b1;
                    dreq_in.addr   = $urandom;
                    dreq_in.size   = msize_t'($urandom_range(0, 3));
                    dreq_in.strobe = 4'($urandom);
                    dreq_in.data   = $urandom;
                end else begin
                    dreq_in = '0;
                end
            end else if (m_owner == 2 && $urandom_range(0, 7) == 0) begin
                dreq_in.addr = $urandom;
            end
            if (m_owner != 0)
                set_ok(1'($urandom), $urandom_range(0, 2) == 0);
            else
                set_ok(1'($urandom), 1'($urandom));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
